egd_sched: RTL and testbench

EGD_SCHED -- requirements
Module: egd_sched

---
 rtl/egd_pkg.sv | 26 ++
 rtl/egd_sched_if.sv | 30 +++
 rtl/egd_rr_arb.sv | 34 +++
 rtl/egd_sched.sv | 143 ++++++++++++++
 tb/tb_egd_sched.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/egd_pkg.sv
// egd_pkg -- shared types and constants for the exp-Golomb decode scheduler.
//   state_t   : scheduler FSM states
//   eg_sel_t  : exp_golomb_sel decoder mode encodings
//   WORD_BITS_DFLT, LEVEL_W, LEVEL_MAX : bit-buffer sizing
package egd_pkg;
   localparam int NUM_REQ        = 2;
   localparam int SEL_W          = 2;
   localparam int WORD_BITS_DFLT = 16;
   localparam int LEVEL_W        = 6;
   localparam int LEVEL_MAX      = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_FILL  = 3'd4
   } state_t;

   typedef enum logic [SEL_W-1:0] {
      EG_UE = 2'd0,  // unsigned
      EG_SE = 2'd1,  // signed
      EG_TE = 2'd2,  // truncated
      EG_K1 = 2'd3   // order-1
   } eg_sel_t;
endpackage

// File: rtl/egd_sched_if.sv
// egd_sched_if -- bundles requester, response, decoder and refill signals.
//   slave  : scheduler side (drives req_ready, rsp_*, dec_start/sel, fill_req)
//   master : environment side (requesters, decoder, bitstream loader)
interface egd_sched_if;
   import egd_pkg::*;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*SEL_W-1:0] req_sel;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     rsp_valid;
   logic                     rsp_id;
   logic [7:0]               rsp_data;
   logic                     rsp_err;
   logic                     rsp_ready;
   logic                     dec_start;
   logic [SEL_W-1:0]         dec_sel;
   logic                     dec_done;
   logic [7:0]               dec_data;
   logic [4:0]               dec_len;
   logic                     fill_req;
   logic                     fill_ack;

   modport slave (
      input  req_valid, req_sel, rsp_ready, dec_done, dec_data, dec_len, fill_ack,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, dec_start, dec_sel, fill_req
   );
   modport master (
      output req_valid, req_sel, rsp_ready, dec_done, dec_data, dec_len, fill_ack,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, dec_start, dec_sel, fill_req
   );
endinterface

// File: rtl/egd_rr_arb.sv
// egd_rr_arb -- two-requester round-robin arbiter.
//   clk, reset : clock, async active-high reset
//   req        : per-requester valid
//   en         : grant allowed this cycle
//   gnt        : one-hot grant (doubles as req_ready)
//   gnt_id     : index of the winner
// A lone requester wins regardless of the pointer; the pointer moves past
// the winner whenever a grant is issued (grant implies a valid request, so
// every grant is an accepted handshake).
module egd_rr_arb
   import egd_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_id
);
   logic ptr;

   always_comb begin
      gnt_id = ptr;
      if (req == 2'b01)      gnt_id = 1'b0;
      else if (req == 2'b10) gnt_id = 1'b1;
      gnt = '0;
      if (en && (|req)) gnt[gnt_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       ptr <= 1'b0;
      else if (|gnt)   ptr <= ~gnt_id;
   end
endmodule

// File: rtl/egd_sched.sv
// egd_sched -- schedules two requesters onto one exp-Golomb decoder and keeps
// the decoder's bit buffer topped up.
//   clk, reset : clock, async active-high reset
//   bus        : egd_sched_if.slave (requests, response, decoder, refill)
// Buffer refill has priority over any request whenever fewer than WORD_BITS
// bits are buffered, so a decode can never run short of bits.
// Optional: EGD_SCHED_TIMEOUT_EN bounds the dec_done wait to TIMEOUT cycles;
// on expiry a response with rsp_err=1 and rsp_data=0 is returned.
module egd_sched
   import egd_pkg::*;
#(
   parameter int TIMEOUT   = 15,
   parameter int WORD_BITS = WORD_BITS_DFLT
)(
   input  logic        clk,
   input  logic        reset,
   egd_sched_if.slave  bus
);
   localparam logic [LEVEL_W-1:0] WB_L   = LEVEL_W'(WORD_BITS);
   localparam logic [4:0]         WB_LEN = 5'(WORD_BITS);
   localparam logic [LEVEL_W:0]   LMAX   = (LEVEL_W+1)'(LEVEL_MAX);

   state_t             state;
   logic [LEVEL_W-1:0] level;
   eg_sel_t            sel_q;
   logic               id_q;
   logic [7:0]         data_q;
   logic               rsp_valid_q;
   logic               dec_start_q;
   logic               fill_req_q;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_id;
   logic               fire;
   logic [4:0]         len_c;
   logic [LEVEL_W:0]   fill_sum;

   egd_rr_arb u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (bus.req_valid),
      .en     ((state == S_IDLE) && (level >= WB_L)),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign fire = |(gnt & bus.req_valid);
   // Out-of-range lengths are treated as a full word consumed.
   assign len_c    = ((bus.dec_len == 5'd0) || (bus.dec_len > WB_LEN)) ? WB_LEN : bus.dec_len;
   assign fill_sum = {1'b0, level} + {1'b0, WB_L};

`ifdef EGD_SCHED_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TMO_W-1:0] wait_cnt;
   logic             err_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         level       <= '0;
         sel_q       <= EG_UE;
         id_q        <= 1'b0;
         data_q      <= '0;
         rsp_valid_q <= 1'b0;
         dec_start_q <= 1'b0;
         fill_req_q  <= 1'b0;
`ifdef EGD_SCHED_TIMEOUT_EN
         wait_cnt    <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (level < WB_L) begin
                  fill_req_q <= 1'b1;
                  state      <= S_FILL;
               end else if (fire) begin
                  sel_q       <= eg_sel_t'(gnt_id ? bus.req_sel[3:2] : bus.req_sel[1:0]);
                  id_q        <= gnt_id;
                  dec_start_q <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               dec_start_q <= 1'b0;
`ifdef EGD_SCHED_TIMEOUT_EN
               wait_cnt    <= '0;
`endif
               state       <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.dec_done) begin
                  data_q      <= bus.dec_data;
                  level       <= level - LEVEL_W'(len_c);
                  rsp_valid_q <= 1'b1;
`ifdef EGD_SCHED_TIMEOUT_EN
                  err_q       <= 1'b0;
`endif
                  state       <= S_RESP;
               end
`ifdef EGD_SCHED_TIMEOUT_EN
               else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
                  // Give up on the decoder; buffered bits are left untouched.
                  data_q      <= '0;
                  err_q       <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state       <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            S_FILL: begin
               if (bus.fill_ack) begin
                  level      <= (fill_sum > LMAX) ? LMAX[LEVEL_W-1:0] : fill_sum[LEVEL_W-1:0];
                  fill_req_q <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = gnt;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = data_q;
   assign bus.dec_start = dec_start_q;
   assign bus.dec_sel   = sel_q;
   assign bus.fill_req  = fill_req_q;
`ifdef EGD_SCHED_TIMEOUT_EN
   assign bus.rsp_err   = err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_egd_sched.sv
// tb_egd_sched -- directed sequence with randomized data/sel/len, checked
// against a transaction-level model (buffer level, round-robin pointer).
module tb_egd_sched;
   import egd_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   m_level = 0;
   int   m_ptr = 0;

   egd_sched_if bus();

   egd_sched #(.TIMEOUT(15), .WORD_BITS(16)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: normal decode; 1: leave the block stalled in WAIT after dly
   // cycles; 2: no dec_done, expect the timeout response.
   task automatic txn(input logic [1:0] vld, input int len_in, input int hold,
                      input int dly, input int mode);
      logic [3:0] sel;
      logic [7:0] data;
      logic [1:0] exp_sel;
      int w, len, l;
      sel  = 4'($urandom);
      data = 8'($urandom);
      len  = (len_in < 0) ? int'($urandom_range(0, 31)) : len_in;
      bus.req_valid = vld;
      bus.req_sel   = sel;
      if (m_level < 16) begin
         #1 chk("rdy_fill_prio", 32'(bus.req_ready), 0);
         tick();
         chk("fill_req", 32'(bus.fill_req), 1);
         chk("rdy_in_fill", 32'(bus.req_ready), 0);
         bus.fill_ack = 1'b1;
         tick();
         bus.fill_ack = 1'b0;
         m_level = (m_level + 16 > 32) ? 32 : m_level + 16;
         chk("fill_req_drop", 32'(bus.fill_req), 0);
      end
      chk("level_pre", 32'(dut.level), m_level);
      w = (vld == 2'b01) ? 0 : (vld == 2'b10) ? 1 : m_ptr;
      exp_sel = (w == 1) ? sel[3:2] : sel[1:0];
      #1 chk("req_ready", 32'(bus.req_ready), 1 << w);
      m_ptr = 1 - w;
      tick();
      chk("dec_start", 32'(bus.dec_start), 1);
      chk("dec_sel", 32'(bus.dec_sel), 32'(exp_sel));
      chk("rdy_issue", 32'(bus.req_ready), 0);
      tick();
      chk("dec_start_1cyc", 32'(bus.dec_start), 0);
      if (mode == 2) begin
         for (int i = 0; i < 15; i++) begin
            chk("tmo_wait", 32'(bus.rsp_valid), 0);
            tick();
         end
         chk("tmo_valid", 32'(bus.rsp_valid), 1);
         chk("tmo_err", 32'(bus.rsp_err), 1);
         chk("tmo_data", 32'(bus.rsp_data), 0);
         chk("tmo_id", 32'(bus.rsp_id), w);
         bus.rsp_ready = 1'b1;
         tick();
         bus.rsp_ready = 1'b0;
         chk("tmo_level", 32'(dut.level), m_level);
         return;
      end
      // Stray fill_ack while waiting on the decoder must not add bits.
      for (int i = 0; i < dly; i++) begin
         bus.fill_ack = 1'b1;
         tick();
         chk("wait_no_rsp", 32'(bus.rsp_valid), 0);
         chk("wait_sel", 32'(bus.dec_sel), 32'(exp_sel));
         chk("wait_rdy", 32'(bus.req_ready), 0);
      end
      bus.fill_ack = 1'b0;
      if (mode == 1) return;
      bus.dec_done = 1'b1;
      bus.dec_data = data;
      bus.dec_len  = 5'(len);
      l = (len == 0 || len > 16) ? 16 : len;
      m_level -= l;
      tick();
      bus.dec_done = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         chk("rsp_valid", 32'(bus.rsp_valid), 1);
         chk("rsp_id", 32'(bus.rsp_id), w);
         chk("rsp_data", 32'(bus.rsp_data), 32'(data));
         chk("rsp_err", 32'(bus.rsp_err), 0);
         chk("rsp_rdy", 32'(bus.req_ready), 0);
         if (i < hold) begin
            bus.dec_done = 1'b1;  // ignored outside WAIT
            bus.dec_data = ~data;
            tick();
            bus.dec_done = 1'b0;
         end
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("rsp_drop", 32'(bus.rsp_valid), 0);
      chk("level_post", 32'(dut.level), m_level);
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_ready"}, 32'(bus.req_ready), 0);
      chk({tag, "_rvalid"}, 32'(bus.rsp_valid), 0);
      chk({tag, "_rid"}, 32'(bus.rsp_id), 0);
      chk({tag, "_rdata"}, 32'(bus.rsp_data), 0);
      chk({tag, "_rerr"}, 32'(bus.rsp_err), 0);
      chk({tag, "_dstart"}, 32'(bus.dec_start), 0);
      chk({tag, "_dsel"}, 32'(bus.dec_sel), 0);
      chk({tag, "_fill"}, 32'(bus.fill_req), 0);
      chk({tag, "_level"}, 32'(dut.level), 0);
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_sel   = '0;
      bus.rsp_ready = 1'b0;
      bus.dec_done  = 1'b0;
      bus.dec_data  = '0;
      bus.dec_len   = '0;
      bus.fill_ack  = 1'b0;
      tick();
      tick();
      chk_outs_zero("reset");
      rst = 1'b0;

      // First request after reset: fill first, then decode with len 5 (16->11).
      txn(2'b01, 5, 0, 0, 0);
      // 11 < 16 forces a fill before the grant, leaving 27.
      txn(2'b11, 1, 0, 1, 0);
      // Both valid continuously: grants must alternate.
      for (int i = 0; i < 4; i++) txn(2'b11, 1, 0, 0, 0);
      // Long rsp_ready backpressure.
      txn(2'b11, -1, 10, 2, 0);
      // Lone requester wins regardless of the pointer.
      txn(2'b10, 3, 0, 0, 0);
      txn(2'b10, 0, 0, 0, 0);
      txn(2'b01, 20, 1, 0, 0);
      // Randomized traffic.
      for (int i = 0; i < 24; i++) begin
         logic [1:0] v;
         v = 2'($urandom_range(1, 3));
         txn(v, -1, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
      end
`ifdef EGD_SCHED_TIMEOUT_EN
      txn(2'b11, 2, 0, 0, 2);
`endif
      // Decoder never answers: without a timeout the block sits in WAIT.
      txn(2'b11, 0, 0, 12, 1);
      // Reset mid-WAIT: outputs clear immediately, late dec_done ignored.
      rst = 1'b1;
      #1 chk_outs_zero("midrst");
      m_level = 0;
      m_ptr   = 0;
      tick();
      rst = 1'b0;
      bus.dec_done = 1'b1;
      bus.dec_len  = 5'd3;
      bus.dec_data = 8'hff;
      tick();
      chk("post_rst_fill", 32'(bus.fill_req), 1);
      chk("post_rst_rvalid", 32'(bus.rsp_valid), 0);
      tick();
      bus.dec_done = 1'b0;
      chk("post_rst_level", 32'(dut.level), 0);
      bus.fill_ack = 1'b1;
      tick();
      bus.fill_ack = 1'b0;
      m_level = 16;
      txn(2'b11, 4, 0, 0, 0);
      txn(2'b11, -1, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
